// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, parity modes, tuser layout and parity helper
package uart_pkg;
    localparam int UART_MAX_WIDTH = 9;
    localparam int TUSER_PARITY   = 0;
    localparam int TUSER_FRAMING  = 1;
    localparam int TUSER_BREAK    = 2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT
    } uart_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0, PAR_ODD = 2'd1, PAR_EVEN = 2'd2, PAR_RSVD = 2'd3
    } uart_parity_t;

    // Expected parity bit over the low len bits: odd -> XNOR-reduce, even -> XOR-reduce.
    function automatic logic uart_parity(input logic [UART_MAX_WIDTH-1:0] data,
                                         input logic [3:0] len, input uart_parity_t mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < UART_MAX_WIDTH; i++)
            if (i < int'(len)) p = p ^ data[i];
        return (mode == PAR_ODD) ? ~p : p;
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - prescaler emitting one oversample tick every divider_i+1 clocks
module uart_baud_tick #(
    parameter int DIVIDER_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic [DIVIDER_WIDTH-1:0] divider_i,
    output logic                     tick_o
);
    logic [DIVIDER_WIDTH-1:0] r_count;

    assign tick_o = enable_i && !clear_i && (r_count == divider_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i)
            r_count <= '0;
        else if (enable_i)
            r_count <= tick_o ? '0 : r_count + 1'b1;
    end
endmodule

// File: rtl/axis_uart_rx_ovs.sv
// rtl/axis_uart_rx_ovs.sv - oversampling UART receiver with majority voting and AXI-Stream output
import uart_pkg::*;

module axis_uart_rx_ovs #(
    parameter int MAX_DATA_WIDTH = 8,
    parameter int OVS            = 16,
    parameter int DIVIDER_WIDTH  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rx_i,
    input  logic [DIVIDER_WIDTH-1:0]  clk_divider_i,
    input  logic [3:0]                data_bits_i,
    input  logic [1:0]                parity_mode_i,
    input  logic                      two_stop_i,
    output logic [MAX_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [2:0]                m_axis_tuser,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      overrun_o
);
    localparam int              TW     = $clog2(OVS);
    localparam logic [TW-1:0]   T_S0   = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0]   T_S1   = TW'(OVS / 2);
    localparam logic [TW-1:0]   T_S2   = TW'(OVS / 2 + 1);
    localparam logic [TW-1:0]   T_END  = TW'(OVS - 1);
    localparam logic [3:0]      NB_MIN = 4'd5;
    localparam logic [3:0]      NB_MAX = 4'(MAX_DATA_WIDTH);

    uart_state_t               r_state;
    uart_parity_t              r_pmode;
    logic                      r_rx_meta, r_rx_sync, r_rx_prev;
    logic [DIVIDER_WIDTH-1:0]  r_div;
    logic [3:0]                r_nbits, r_bit_idx;
    logic                      r_two_stop, r_stop_idx;
    logic [TW-1:0]             r_tick;
    logic [1:0]                r_samp;
    logic                      r_bit;
    logic [MAX_DATA_WIDTH-1:0] r_shift;
    logic                      r_all_zero, r_par_err, r_frame_err;
    logic [MAX_DATA_WIDTH-1:0] r_tdata;
    logic [2:0]                r_tuser;
    logic                      r_tvalid, r_overrun;

    logic       w_start, w_baud_tick, w_maj, w_par_en, w_brk, w_ferr;
    logic [3:0] w_nbits;
    logic [2:0] w_tuser;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_start  = (r_state == ST_IDLE) && r_rx_prev && !r_rx_sync;
    assign w_maj    = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rx_sync) | (r_samp[1] & r_rx_sync);
    assign w_par_en = (r_pmode == PAR_ODD) || (r_pmode == PAR_EVEN);
    // Evaluated at the last stop-bit mid-sample, where w_maj is that stop bit.
    assign w_brk    = r_all_zero & ~w_maj;
    assign w_ferr   = r_frame_err | ~w_maj;

    always_comb begin
        w_nbits = data_bits_i;
        if (data_bits_i < NB_MIN) w_nbits = NB_MIN;
        if (data_bits_i > NB_MAX) w_nbits = NB_MAX;
        w_tuser = 3'b000;
        w_tuser[TUSER_BREAK]   = w_brk;
        w_tuser[TUSER_FRAMING] = w_ferr;
        w_tuser[TUSER_PARITY]  = r_par_err;
    end

    uart_baud_tick #(.DIVIDER_WIDTH(DIVIDER_WIDTH)) u_baud (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .enable_i  (r_state != ST_IDLE),
        .clear_i   (w_start),
        .divider_i (r_div),
        .tick_o    (w_baud_tick)
    );

    always_ff @(posedge clk_i) begin
        r_overrun <= 1'b0;
        if (r_tvalid && m_axis_tready) r_tvalid <= 1'b0;
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_pmode     <= PAR_NONE;
            r_div       <= '0;
            r_nbits     <= '0;
            r_bit_idx   <= '0;
            r_two_stop  <= 1'b0;
            r_stop_idx  <= 1'b0;
            r_tick      <= '0;
            r_samp      <= '0;
            r_bit       <= 1'b0;
            r_shift     <= '0;
            r_all_zero  <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_tdata     <= '0;
            r_tuser     <= '0;
            r_tvalid    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_start) begin
                    r_state     <= ST_START;
                    r_div       <= clk_divider_i;
                    r_nbits     <= w_nbits;
                    r_pmode     <= uart_parity_t'(parity_mode_i);
                    r_two_stop  <= two_stop_i;
                    r_tick      <= '0;
                    r_bit_idx   <= '0;
                    r_stop_idx  <= 1'b0;
                    r_shift     <= '0;
                    r_all_zero  <= 1'b1;
                    r_par_err   <= 1'b0;
                    r_frame_err <= 1'b0;
                end
                ST_WAIT: if (r_rx_sync) r_state <= ST_IDLE;
                default: if (w_baud_tick) begin
                    r_tick <= r_tick + 1'b1;
                    if (r_tick == T_S0) r_samp[0] <= r_rx_sync;
                    if (r_tick == T_S1) r_samp[1] <= r_rx_sync;
                    if (r_tick == T_S2) begin
                        r_bit <= w_maj;
                        case (r_state)
                            ST_DATA: begin
                                for (int i = 0; i < MAX_DATA_WIDTH; i++)
                                    if (4'(i) == r_bit_idx) r_shift[i] <= w_maj;
                                r_all_zero <= r_all_zero & ~w_maj;
                            end
                            ST_PARITY: begin
                                r_par_err  <= w_maj != uart_parity(UART_MAX_WIDTH'(r_shift), r_nbits, r_pmode);
                                r_all_zero <= r_all_zero & ~w_maj;
                            end
                            ST_STOP: begin
                                if (r_stop_idx == r_two_stop) begin
                                    // Complete early so the next start edge is not missed.
                                    r_state <= w_ferr ? ST_WAIT : ST_IDLE;
                                    if (r_tvalid && !m_axis_tready) begin
                                        r_overrun <= 1'b1;
                                    end else begin
                                        r_tvalid <= 1'b1;
                                        r_tdata  <= r_shift;
                                        r_tuser  <= w_tuser;
                                    end
                                end else begin
                                    r_frame_err <= r_frame_err | ~w_maj;
                                    r_all_zero  <= r_all_zero & ~w_maj;
                                end
                            end
                            default: ;
                        endcase
                    end
                    if (r_tick == T_END) begin
                        case (r_state)
                            ST_START: r_state <= r_bit ? ST_IDLE : ST_DATA;
                            ST_DATA: begin
                                if (r_bit_idx == r_nbits - 4'd1) begin
                                    r_bit_idx <= '0;
                                    r_state   <= w_par_en ? ST_PARITY : ST_STOP;
                                end else begin
                                    r_bit_idx <= r_bit_idx + 4'd1;
                                end
                            end
                            ST_PARITY: r_state <= ST_STOP;
                            ST_STOP:   r_stop_idx <= 1'b1;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tvalid = r_tvalid;
    assign overrun_o     = r_overrun;
endmodule

// File: tb/tb_axis_uart_rx_ovs.sv
// tb/tb_axis_uart_rx_ovs.sv - directed table-driven bench for axis_uart_rx_ovs
module tb_axis_uart_rx_ovs;
    localparam int DIV      = 3;
    localparam int BIT_CLKS = (DIV + 1) * 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] clk_divider = 16'(DIV);
    logic [3:0]  data_bits = 4'd8;
    logic [1:0]  parity_mode = 2'd0;
    logic        two_stop = 1'b0;
    logic [7:0]  tdata;
    logic [2:0]  tuser;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        overrun;

    int n_checks = 0;
    int n_err = 0;
    int n_ovr = 0;
    logic [7:0] beat_data[$];
    logic [2:0] beat_user[$];

    axis_uart_rx_ovs dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rx_i          (rx),
        .clk_divider_i (clk_divider),
        .data_bits_i   (data_bits),
        .parity_mode_i (parity_mode),
        .two_stop_i    (two_stop),
        .m_axis_tdata  (tdata),
        .m_axis_tuser  (tuser),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .overrun_o     (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tvalid && tready) begin
            beat_data.push_back(tdata);
            beat_user.push_back(tuser);
        end
        if (overrun) n_ovr++;
    end

    typedef struct {
        int         nbits;
        logic [1:0] pmode;
        logic       two;
        logic [7:0] data;
        logic       send_par;
        logic       par_val;
        logic       s1;
        logic       s2;
        logic [7:0] exp_data;
        logic [2:0] exp_user;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input int nb, input logic [1:0] pm, input logic two, input logic [7:0] d,
                              input logic send_par, input logic pv, input logic s1, input logic s2);
        data_bits   = nb[3:0];
        parity_mode = pm;
        two_stop    = two;
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (send_par) send_bit(pv);
        send_bit(s1);
        if (two) send_bit(s2);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
    endtask

    task automatic check_beat(input string name, input int base, input int exp_count,
                              input logic [7:0] exp_data, input logic [2:0] exp_user);
        int idx;
        logic [7:0] d;
        logic [2:0] u;
        idx = base + exp_count - 1;
        d = (beat_data.size() > idx) ? beat_data[idx] : 8'hxx;
        u = (beat_user.size() > idx) ? beat_user[idx] : 3'bxxx;
        check({name, "_count"}, 32'(beat_data.size() - base), 32'(exp_count));
        check({name, "_tdata"}, 32'(d), 32'(exp_data));
        check({name, "_tuser"}, 32'(u), 32'(exp_user));
    endtask

    initial begin
        int base;
        int ovr_base;
        vecs[0] = '{8, 2'd0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 3'b000};
        vecs[1] = '{7, 2'd1, 1'b0, 8'h35, 1'b1, 1'b0, 1'b1, 1'b1, 8'h35, 3'b001};
        vecs[2] = '{7, 2'd1, 1'b0, 8'h35, 1'b1, 1'b1, 1'b1, 1'b1, 8'h35, 3'b000};
        vecs[3] = '{8, 2'd0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 3'b010};
        vecs[4] = '{8, 2'd0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 3'b000};
        vecs[5] = '{8, 2'd2, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 3'b000};
        vecs[6] = '{8, 2'd2, 1'b0, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 3'b001};
        vecs[7] = '{5, 2'd0, 1'b0, 8'h15, 1'b0, 1'b0, 1'b1, 1'b1, 8'h15, 3'b000};
        vecs[8] = '{6, 2'd0, 1'b0, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2A, 3'b010};
        vecs[9] = '{8, 2'd3, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 3'b000};

        wait_clks(4);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tdata", 32'(tdata), 32'd0);
        check("rst_tuser", 32'(tuser), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        wait_clks(2 * BIT_CLKS);

        for (int v = 0; v < 10; v++) begin
            base = beat_data.size();
            send_frame(vecs[v].nbits, vecs[v].pmode, vecs[v].two, vecs[v].data,
                       vecs[v].send_par, vecs[v].par_val, vecs[v].s1, vecs[v].s2);
            check_beat($sformatf("vec%0d", v), base, 1, vecs[v].exp_data, vecs[v].exp_user);
        end

        // Break: line low for 20 bit times gives one beat, then silence until a new start.
        data_bits = 4'd8; parity_mode = 2'd0; two_stop = 1'b0;
        base = beat_data.size();
        rx = 1'b0;
        wait_clks(20 * BIT_CLKS);
        check_beat("break", base, 1, 8'h00, 3'b110);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("break_quiet", 32'(beat_data.size() - base), 32'd1);
        send_frame(8, 2'd0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
        check_beat("after_break", base, 2, 8'h81, 3'b000);

        // Overrun: held 0x11 survives, 0x22 is dropped with a single pulse.
        tready = 1'b0;
        base = beat_data.size();
        ovr_base = n_ovr;
        send_frame(8, 2'd0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ovr_none_yet", 32'(n_ovr - ovr_base), 32'd0);
        send_frame(8, 2'd0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ovr_pulse", 32'(n_ovr - ovr_base), 32'd1);
        check("ovr_tvalid_held", 32'(tvalid), 32'd1);
        check("ovr_tdata_held", 32'(tdata), 32'h11);
        tready = 1'b1;
        wait_clks(BIT_CLKS);
        check_beat("ovr_drain", base, 1, 8'h11, 3'b000);
        check("ovr_tvalid_low", 32'(tvalid), 32'd0);

        // Quarter-bit glitch is a false start.
        base = beat_data.size();
        rx = 1'b0;
        wait_clks(BIT_CLKS / 4);
        rx = 1'b1;
        wait_clks(3 * BIT_CLKS);
        check("glitch_none", 32'(beat_data.size() - base), 32'd0);

        // Reset mid-byte of 0x96 while the line is high, then a clean 0x96.
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b1;
        wait_clks(BIT_CLKS / 2);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(12 * BIT_CLKS);
        check("rst_mid_none", 32'(beat_data.size() - base), 32'd0);
        send_frame(8, 2'd0, 1'b0, 8'h96, 1'b0, 1'b0, 1'b1, 1'b1);
        check_beat("after_rst", base, 1, 8'h96, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/axis_uart_rx_ovs.md
AXIS_UART_RX_OVS -- requirements
Module: axis_uart_rx_ovs

Interface
REQ-001 Parameter MAX_DATA_WIDTH, default 8: widest supported character in bits; legal range 5..9.
REQ-002 Parameter OVS, default 16: oversampling ticks per bit; power of two, minimum 8.
REQ-003 Parameter DIVIDER_WIDTH, default 16: width of the prescaler divider input.
REQ-004 clk_i  input  1: sole clock.
REQ-005 rst_i  input  1: reset, synchronous and active-high.
REQ-006 rx_i  input  1: serial line; asynchronous to clk_i; idles high.
REQ-007 clk_divider_i  input  DIVIDER_WIDTH: one oversample tick every clk_divider_i+1 clocks.
REQ-008 data_bits_i  input  4: character length; legal range 5..MAX_DATA_WIDTH.
REQ-009 parity_mode_i  input  2: 0 none, 1 odd, 2 even, 3 reserved (treated as none).
REQ-010 two_stop_i  input  1: 1 selects two stop bits.
REQ-011 m_axis_tdata  output  MAX_DATA_WIDTH: received character, LSB first on the line, zero-extended.
REQ-012 m_axis_tuser  output  3: bit 2 break, bit 1 framing error, bit 0 parity error.
REQ-013 m_axis_tvalid  output  1 / m_axis_tready  input  1: AXI-Stream handshake.
REQ-014 overrun_o  output  1: one-cycle pulse when a completed character is dropped.

Function
REQ-015 rx_i SHALL pass through a 2-flop synchroniser before any use; reset value 1.
REQ-016 The prescaler SHALL count 0..clk_divider_i and emit a one-clock tick at the terminal count; it runs only outside IDLE and restarts at 0 on entry to START.
REQ-017 Within each bit the tick counter SHALL run 0..OVS-1; the bit value SHALL be the 2-of-3 majority of samples at ticks OVS/2-1, OVS/2 and OVS/2+1.
REQ-018 State machine states: IDLE, START, DATA, PARITY, STOP, WAIT.
REQ-019 IDLE -> START on a synchronised falling edge of rx_i.
REQ-020 START: at the end of the bit, majority 0 -> DATA; majority 1 -> IDLE as a false start, producing no output.
REQ-021 data_bits_i, parity_mode_i, two_stop_i and clk_divider_i SHALL be latched on IDLE -> START; changes mid-frame have no effect on that frame.
REQ-022 DATA SHALL shift in the latched number of bits LSB first, then go to PARITY if parity is enabled, otherwise to STOP.
REQ-023 The parity error flag SHALL be set if the received parity bit differs from the expected bit: XNOR-reduce of the data for odd, XOR-reduce for even.
REQ-024 STOP: framing error if any stop-bit majority is 0; with two_stop the second stop bit is also checked.
REQ-025 The frame SHALL complete at the mid-sample (tick OVS/2+1) of the last stop bit, without waiting for the bit end, so the receiver resynchronises early.
REQ-026 Break SHALL be flagged when all data bits, the parity bit (if enabled) and the stop bit are 0; break implies framing error, and the FSM then goes to WAIT.
REQ-027 On frame completion the FSM SHALL go to IDLE; after a break or framing error it SHALL go to WAIT, which returns to IDLE once the synchronised rx_i is 1.
REQ-028 m_axis_tvalid SHALL rise the clock after frame completion, together with tdata and tuser.
REQ-029 tdata/tuser SHALL hold stable while tvalid=1 and tready=0; tvalid SHALL fall the clock after a cycle with tvalid and tready both 1.
REQ-030 Completion with tvalid=1 and tready=0 SHALL drop the new character, pulse overrun_o for one clock, and leave the held beat untouched.
REQ-031 Completion in the same clock as a tvalid&tready handshake is not an overrun; the new beat is presented next clock.

Reset
REQ-032 While rst_i=1: FSM in IDLE, all counters 0, synchroniser at 1, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, overrun_o=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no output; after release the receiver waits for a fresh falling edge.

Structure
REQ-034 The state enum, the parity-mode encoding, the tuser bit positions and the parity function (widened to MAX_DATA_WIDTH with a length argument) SHALL live in the shared UART package.
REQ-035 The prescaler/tick generator SHALL be a separate sub-module, uart_baud_tick, reused by the transmitter.

Verification
REQ-036 Test 1: divider=3, 8 data bits, no parity, 1 stop, byte 0xA5 sent, tready=1 -> one beat with tdata=0xA5 and tuser=0.
REQ-037 Test 2: 7 data bits, odd parity, byte 0x35 with wrong parity bit 0 -> tdata=0x35, tuser=3'b001; same byte with parity bit 1 -> tuser=0.
REQ-038 Test 3: 2 stop bits with the second stop bit driven 0 -> tuser=3'b010, then WAIT until rx is high; a following 0x5A is received cleanly.
REQ-039 Test 4: rx held low for 20 bit times -> exactly one beat with tdata=0 and tuser=3'b110; no further beats until rx is high and a new start bit arrives.
REQ-040 Test 5: tready=0, bytes 0x11 then 0x22 -> beat 0x11 held, one overrun_o pulse, 0x22 never appears.
REQ-041 Test 6: 0.25-bit low glitch -> no output; rst_i pulsed mid-byte -> no output, and the next full byte is received correctly.
